// File: rtl/imem_sync.sv
// Synchronous instruction memory for the IF stage.
// Cleared after reset, loaded through a program port, one-cycle fetch.
module imem_sync #(
   parameter int N     = 32,
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          flush,
   input  logic [N-1:0]  pc,
   output logic [N-1:0]  instruction,
   output logic          valid,
   output logic          fault,
   output logic          ready,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [N-1:0]  prog_data
);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

   logic [N-1:0]  mem [DEPTH];

   state_t        state_q, state_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [N-1:0]  instr_q, instr_d;
   logic          valid_q, valid_d;
   logic          fault_q, fault_d;
   logic          ready_q, ready_d;

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [N-1:0]  mem_wdata;

   logic [AW-1:0] idx;
   logic          oor;
   logic          mis;
   logic [N-1:0]  rd_word;

   assign idx = pc[AW+1:2];
   assign oor = |(pc >> (AW + 2));
   assign mis = |pc[1:0];

   // Write-first read: a same-cycle program write to the fetched word wins.
   assign rd_word = (prog_we && prog_addr == idx) ? prog_data : mem[idx];

   // Next-state, memory write port and fetch register selection.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      fault_d   = fault_q;
      ready_d   = ready_q;
      mem_we    = 1'b0;
      mem_waddr = prog_addr;
      mem_wdata = prog_data;
      unique case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[AW-1:0];
            mem_wdata = '0;
            instr_d   = '0;
            valid_d   = 1'b0;
            fault_d   = 1'b0;
            ready_d   = 1'b0;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = RUN;
               ready_d = 1'b1;
            end
         end
         RUN: begin
            mem_we = prog_we;
            if (flush) begin
               instr_d = '0;
               valid_d = 1'b0;
               fault_d = 1'b0;
            end else if (en) begin
               valid_d = 1'b1;
               if (oor || mis) begin
                  instr_d = '0;
                  fault_d = 1'b1;
               end else begin
                  instr_d = rd_word;
                  fault_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   // Control FSM and registered fetch outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
         ready_q <= ready_d;
      end
   end

   // Storage array; only the sweep zeroes it, never the reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign instruction = instr_q;
   assign valid       = valid_q;
   assign fault       = fault_q;
   assign ready       = ready_q;

endmodule

// File: tb/tb_imem_sync.sv
// Directed bench for imem_sync with DEPTH=16.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_imem_sync;

   localparam int N     = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          flush = 1'b0;
   logic [N-1:0]  pc = '0;
   logic [N-1:0]  instruction;
   logic          valid;
   logic          fault;
   logic          ready;
   logic          prog_we = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [N-1:0]  prog_data = '0;

   int total = 0;
   int bad   = 0;

   imem_sync #(.N(N), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .flush       (flush),
      .pc          (pc),
      .instruction (instruction),
      .valid       (valid),
      .fault       (fault),
      .ready       (ready),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] got,
                      input logic [N-1:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [N-1:0] ei,
                          input logic ev, input logic ef);
      chk({tag, ".instr"}, instruction, ei);
      chk({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
      chk({tag, ".fault"}, {31'd0, fault}, {31'd0, ef});
   endtask

   initial begin
      // Reset values while held in reset
      #2;
      chk_out("rst", 32'h0, 1'b0, 1'b0);
      chk("rst.ready", {31'd0, ready}, 32'd0);
      step();
      step();
      rst = 1'b1;
      en  = 1'b1;

      // Clear sweep: ready rises on the 16th edge
      for (int i = 1; i <= DEPTH; i++) begin
         step();
         chk($sformatf("clr.ready%0d", i), {31'd0, ready},
             {31'd0, (i == DEPTH)});
         if (i == 5) chk_out("clr.out", 32'h0, 1'b0, 1'b0);
      end

      // Every word reads zero after the sweep
      for (int p = 0; p <= 60; p += 4) begin
         pc = p;
         step();
         chk_out($sformatf("zero%0d", p), 32'h0, 1'b1, 1'b0);
      end

      // Load two words
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = 32'hE3A00014;
      step();
      prog_addr = 4'd1;
      prog_data = 32'hE3A01A01;
      step();
      prog_we = 1'b0;

      pc = 32'd0;
      step();
      chk_out("ld0", 32'hE3A00014, 1'b1, 1'b0);
      pc = 32'd4;
      step();
      chk_out("ld1", 32'hE3A01A01, 1'b1, 1'b0);

      // Stall while pc changes
      en = 1'b0;
      pc = 32'd0;
      step();
      chk_out("stall1", 32'hE3A01A01, 1'b1, 1'b0);
      pc = 32'd64;
      step();
      chk_out("stall2", 32'hE3A01A01, 1'b1, 1'b0);
      pc = 32'd6;
      step();
      chk_out("stall3", 32'hE3A01A01, 1'b1, 1'b0);

      // Flush overrides stall
      flush = 1'b1;
      step();
      chk_out("flush", 32'h0, 1'b0, 1'b0);
      flush = 1'b0;

      // Re-enable fetches the pc present at that edge
      en = 1'b1;
      pc = 32'd0;
      step();
      chk_out("reen", 32'hE3A00014, 1'b1, 1'b0);

      // Faults
      pc = 32'd64;
      step();
      chk_out("oor", 32'h0, 1'b1, 1'b1);
      pc = 32'd6;
      step();
      chk_out("mis", 32'h0, 1'b1, 1'b1);
      pc = 32'd8;
      step();
      chk_out("ok8", 32'h0, 1'b1, 1'b0);

      // Write-first on same word
      prog_we   = 1'b1;
      prog_addr = 4'd2;
      prog_data = 32'h12345678;
      pc        = 32'd8;
      step();
      chk_out("wfirst", 32'h12345678, 1'b1, 1'b0);

      // Flush with write: write lands, fetch killed
      flush     = 1'b1;
      prog_addr = 4'd3;
      prog_data = 32'hAABBCCDD;
      pc        = 32'd12;
      step();
      chk_out("flwr", 32'h0, 1'b0, 1'b0);
      flush   = 1'b0;
      prog_we = 1'b0;
      step();
      chk_out("flwr.rd", 32'hAABBCCDD, 1'b1, 1'b0);

      // Asynchronous reset mid-run
      #2;
      rst = 1'b0;
      #1;
      chk_out("arst", 32'h0, 1'b0, 1'b0);
      chk("arst.ready", {31'd0, ready}, 32'd0);
      step();
      rst = 1'b1;

      // Writes during the sweep are ignored
      prog_we   = 1'b1;
      prog_addr = 4'd1;
      prog_data = 32'hDEADBEEF;
      for (int i = 1; i <= DEPTH; i++) begin
         step();
         if (i == DEPTH - 1)
            chk("rclr.ready15", {31'd0, ready}, 32'd0);
      end
      chk("rclr.ready16", {31'd0, ready}, 32'd1);
      prog_we = 1'b0;

      pc = 32'd0;
      step();
      chk_out("rz0", 32'h0, 1'b1, 1'b0);
      pc = 32'd4;
      step();
      chk_out("rz1", 32'h0, 1'b1, 1'b0);
      pc = 32'd8;
      step();
      chk_out("rz2", 32'h0, 1'b1, 1'b0);
      pc = 32'd12;
      step();
      chk_out("rz3", 32'h0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
